// File: rtl/mem_arb_pkg.sv
// Shared types and parameter defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_MEM_LAT    = 2;
  localparam int unsigned DEF_STARVE_MAX = 4;

  // Wide enough for the 1..15 legal range of MEM_LAT and STARVE_MAX.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/arb_wait_counter.sv
// Wait-state down-counter: loadable, decrements on request, flags zero.
module arb_wait_counter #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory (IDLE/ACCESS/DONE).
// Define MEM_ARB_STARVE_GUARD_EN to bound consecutive data grants while fetch waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t r_state;
  owner_t r_owner;
  logic   w_any_req;
  logic   w_pick_if;
  logic   w_zero;
  logic   w_load;
  logic   w_dec;

  assign w_any_req = if_req | dm_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] r_streak;

  assign w_pick_if = if_req && (!dm_req || (r_streak == CNT_W'(STARVE_MAX)));

  // Streak only grows on a dm grant that left a fetch waiting.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_streak <= '0;
    end else if (r_state == IDLE) begin
      if (!if_req || w_pick_if) begin
        r_streak <= '0;
      end else begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end
`else
  assign w_pick_if = if_req && !dm_req;
`endif

  // Grants are combinational; gated by Reset so none appears while held in reset.
  assign if_gnt = Reset && (r_state == IDLE) && w_pick_if;
  assign dm_gnt = Reset && (r_state == IDLE) && dm_req && !w_pick_if;

  assign w_load = (r_state == IDLE) && w_any_req;
  assign w_dec  = (r_state == ACCESS) && !w_zero;

  arb_wait_counter #(
    .W (CNT_W)
  ) u_wait_cnt (
    .i_clk      (Clock),
    .i_rst_n    (Reset),
    .i_load     (w_load),
    .i_load_val (CNT_W'(MEM_LAT - 1)),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_owner   <= OWN_IF;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_valid  <= 1'b0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            mem_en <= 1'b1;
            if (w_pick_if) begin
              r_owner  <= OWN_IF;
              mem_addr <= if_addr;
              mem_we   <= 1'b0;
            end else begin
              r_owner   <= OWN_DM;
              mem_addr  <= dm_addr;
              mem_we    <= dm_we;
              mem_wdata <= dm_wdata;
            end
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_zero) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (r_owner == OWN_IF) begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              dm_valid <= 1'b1;
              // Write acks keep the previous read data.
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          if_valid <= 1'b0;
          dm_valid <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
module tb_mem_port_arbiter;

  logic        Clock;
  logic        Reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_LAT    (2),
    .STARVE_MAX (4)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_valid  (dm_valid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  logic exp_if_win;

  initial begin
    Reset = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    #12;
    if_req = 1'b1;
    #1;
    check("rst_if_gnt", if_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    if_req = 1'b0;
    @(negedge Clock); Reset = 1'b1;

    // Fetch: grant c0, memory c1-c2, valid c3
    cyc(); if_req = 1'b1; if_addr = 32'h4; mem_rdata = 32'h8C010000; #1;
    check("f_c0_if_gnt", if_gnt, 1);
    check("f_c0_dm_gnt", dm_gnt, 0);
    check("f_c0_mem_en", mem_en, 0);
    cyc(); if_req = 1'b0; #1;
    check("f_c1_mem_en", mem_en, 1);
    check("f_c1_addr", mem_addr, 32'h4);
    check("f_c1_we", mem_we, 0);
    check("f_c1_if_gnt", if_gnt, 0);
    cyc(); #1;
    check("f_c2_mem_en", mem_en, 1);
    check("f_c2_valid", if_valid, 0);
    cyc(); #1;
    check("f_c3_valid", if_valid, 1);
    check("f_c3_rdata", if_rdata, 32'h8C010000);
    check("f_c3_mem_en", mem_en, 0);
    check("f_c3_dm_valid", dm_valid, 0);
    cyc(); #1;
    check("f_c4_valid", if_valid, 0);

    // Store
    cyc(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEADBEEF; #1;
    check("s_c0_dm_gnt", dm_gnt, 1);
    check("s_c0_if_gnt", if_gnt, 0);
    cyc(); dm_req = 1'b0; dm_we = 1'b0; #1;
    check("s_c1_we", mem_we, 1);
    check("s_c1_addr", mem_addr, 32'h10);
    check("s_c1_wdata", mem_wdata, 32'hDEADBEEF);
    cyc(); #1;
    check("s_c2_we", mem_we, 1);
    check("s_c2_en", mem_en, 1);
    cyc(); #1;
    check("s_c3_dm_valid", dm_valid, 1);
    check("s_c3_dm_rdata_held", dm_rdata, 0);
    check("s_c3_if_rdata_held", if_rdata, 32'h8C010000);
    check("s_c3_if_valid", if_valid, 0);
    check("s_c3_we", mem_we, 0);
    cyc(); #1;
    check("s_c4_dm_valid", dm_valid, 0);

    // Data read
    cyc(); dm_req = 1'b1; dm_addr = 32'h20; mem_rdata = 32'h12345678; #1;
    check("r_c0_dm_gnt", dm_gnt, 1);
    cyc(); dm_req = 1'b0; #1;
    check("r_c1_we", mem_we, 0);
    check("r_c1_addr", mem_addr, 32'h20);
    cyc(); cyc(); #1;
    check("r_c3_dm_valid", dm_valid, 1);
    check("r_c3_dm_rdata", dm_rdata, 32'h12345678);
    check("r_c3_if_rdata_held", if_rdata, 32'h8C010000);

    // Collision: dm first, fetch waits and is granted at c4
    cyc(); cyc();
    if_req = 1'b1; if_addr = 32'h40; dm_req = 1'b1; dm_addr = 32'h30; mem_rdata = 32'hCAFEF00D; #1;
    check("c_c0_dm_gnt", dm_gnt, 1);
    check("c_c0_if_gnt", if_gnt, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (i == 1) dm_req = 1'b0;
      #1;
      check("c_wait_if_gnt", if_gnt, 0);
    end
    cyc(); #1;
    check("c_c4_if_gnt", if_gnt, 1);
    check("c_c4_dm_gnt", dm_gnt, 0);
    cyc(); if_req = 1'b0; #1;
    check("c_c5_addr", mem_addr, 32'h40);
    cyc(); #1;
    check("c_c6_if_valid", if_valid, 0);
    cyc(); #1;
    check("c_c7_if_valid", if_valid, 1);
    check("c_c7_if_rdata", if_rdata, 32'hCAFEF00D);

    // Fetch request raised while busy, withdrawn before IDLE: dropped
    cyc(); cyc(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h50; dm_wdata = 32'h1; #1;
    check("w_c0_dm_gnt", dm_gnt, 1);
    cyc(); dm_req = 1'b0; dm_we = 1'b0; if_req = 1'b1; #1;
    check("w_c1_if_gnt", if_gnt, 0);
    cyc(); cyc(); if_req = 1'b0; #1;
    cyc(); #1;
    check("w_c4_if_gnt", if_gnt, 0);
    check("w_c4_mem_en", mem_en, 0);
    cyc(); #1;
    check("w_c5_mem_en", mem_en, 0);

    // Both held continuously: five decisions, 4 cycles apart
    cyc(); if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) repeat (4) cyc();
      #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_if_win = (k == 4);
`else
      exp_if_win = 1'b0;
`endif
      check("st_if_gnt", if_gnt, exp_if_win);
      check("st_dm_gnt", dm_gnt, !exp_if_win);
    end
    cyc(); if_req = 1'b0; dm_req = 1'b0;
    repeat (6) cyc();

    // Reset during ACCESS abandons the fetch
    if_req = 1'b1; if_addr = 32'h60; mem_rdata = 32'h11112222; #1;
    check("rm_c0_if_gnt", if_gnt, 1);
    cyc(); if_req = 1'b0; #1;
    check("rm_c1_mem_en", mem_en, 1);
    Reset = 1'b0; #1;
    check("rm_async_mem_en", mem_en, 0);
    check("rm_async_addr", mem_addr, 0);
    check("rm_async_if_rdata", if_rdata, 0);
    check("rm_async_dm_rdata", dm_rdata, 0);
    repeat (2) cyc();
    @(negedge Clock); Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      check("rm_no_valid", if_valid, 0);
      check("rm_no_mem_en", mem_en, 0);
    end
    if_req = 1'b1; if_addr = 32'h8; mem_rdata = 32'hAAAA5555; #1;
    check("rm_f_c0_if_gnt", if_gnt, 1);
    cyc(); if_req = 1'b0; #1;
    check("rm_f_c1_addr", mem_addr, 32'h8);
    cyc(); cyc(); #1;
    check("rm_f_c3_valid", if_valid, 1);
    check("rm_f_c3_rdata", if_rdata, 32'hAAAA5555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 32, data width.
REQ-003 SHALL have parameter MEM_LAT, 2, memory access cycles (legal range 1..15).
REQ-004 SHALL have parameter STARVE_MAX, 4, consecutive data grants allowed while fetch waits (legal range 1..15).
REQ-005 SHALL have port Clock  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports if_req in 1, if_addr in ADDR_W: instruction-fetch request and address.
REQ-008 SHALL have ports if_gnt out 1, if_valid out 1, if_rdata out DATA_W: fetch grant, response strobe, read data.
REQ-009 SHALL have ports dm_req in 1, dm_we in 1, dm_addr in ADDR_W, dm_wdata in DATA_W: data-port request.
REQ-010 SHALL have ports dm_gnt out 1, dm_valid out 1, dm_rdata out DATA_W: data-port grant, response strobe, read data.
REQ-011 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W: single-port memory side.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-013 In IDLE with any request, SHALL assert exactly one of if_gnt/dm_gnt combinationally for that cycle; no grant outside IDLE.
REQ-014 On the granting edge, SHALL latch owner, address, we and wdata, load wait counter with MEM_LAT-1, and enter ACCESS.
REQ-015 In ACCESS, SHALL drive mem_en=1 with mem_addr/mem_we/mem_wdata stable from latched values; mem_we=0 for fetches.
REQ-016 In ACCESS, SHALL decrement the counter each cycle; at count 0, register mem_rdata and enter DONE.
REQ-017 In DONE, SHALL pulse the owner's valid for exactly one cycle with registered rdata (writes: valid pulses as ack, rdata held at previous value), then return to IDLE.
REQ-018 Latency SHALL be: valid asserted exactly MEM_LAT+1 cycles after the grant cycle; throughput one access per MEM_LAT+2 cycles.
REQ-019 Simultaneous if_req and dm_req SHALL grant dm (default priority), subject to REQ-024.
REQ-020 Requests arriving outside IDLE SHALL be held by the requester; arbiter SHALL not queue them.
REQ-021 A request withdrawn before grant SHALL be dropped with no memory activity.
REQ-022 rdata outputs of the non-owning port SHALL hold their previous value; valid of the non-owner SHALL stay 0.

Reset
REQ-023 Reset low SHALL immediately force IDLE, counter 0, streak 0, all gnt/valid/mem_en/mem_we 0, all data/address outputs 0; an in-flight access SHALL be abandoned with no valid pulse.

Configuration
REQ-024 With MEM_ARB_STARVE_GUARD_EN defined: a streak counter SHALL count dm grants made while if_req is high, clear on any if grant or when if_req is low at an IDLE decision; when streak equals STARVE_MAX, the next simultaneous decision SHALL grant if.
REQ-025 Without MEM_ARB_STARVE_GUARD_EN: strict dm priority, no streak counter logic present.

Structure
REQ-026 Package mem_arb_pkg SHALL hold the state enum, owner encoding (OWN_IF, OWN_DM) and parameter defaults.
REQ-027 Wait-state down-counter SHALL be sub-module arb_wait_counter (load, decrement, zero flag).

Verification (MEM_LAT=2, STARVE_MAX=4)
REQ-028 Fetch: if_req=1, if_addr=0x00000004, mem_rdata=0x8C010000 -> if_gnt cycle 0, mem_en cycles 1-2 addr 0x00000004 we=0, if_valid cycle 3 with if_rdata=0x8C010000.
REQ-029 Store: dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF -> dm_gnt cycle 0, mem_we=1 cycles 1-2 with that addr/data, dm_valid cycle 3.
REQ-030 Collision: if_req and dm_req both high at cycle 0 -> dm_gnt cycle 0, if_gnt cycle 4, if_valid cycle 7.
REQ-031 Starvation (macro defined): both held high continuously -> grants dm,dm,dm,dm,if; macro undefined -> dm only, if_gnt never.
REQ-032 Reset mid-op: Reset low during ACCESS cycle 1 -> mem_en=0 immediately, no valid pulse; after release, fresh request served normally.
